quad_sample_scheduler: RTL and testbench
========================================

// Module: quad_sample_scheduler
// PURPOSE
//  Periodic sampling scheduler for a bank of quadrature-decoder position counters.
//  - A programmable tick snapshots all encoder counts in the same cycle.
//  - Channels are then sequenced one at a time: zero offset applied, delta vs. previous frame computed.
//  - Each channel is emitted as one position/velocity record on a valid/ready stream to the host interface.
// PARAMETERS
//  NUM_ENC  4   number of encoder channels (>=1)
//  CNT_W    32  width of each decoder count and of out_position
//  VEL_W    16  signed velocity width (counts per sample period)
//  PER_W    24  width of sample_period
// PORTS
//  clk            in   1              system clock
//  reset_n        in   1              asynchronous, active-low reset
//  enable         in   1              1 = prescaler runs; 0 = current frame completes, no new ticks
//  sample_period  in   PER_W          tick every sample_period+1 clk cycles
//  enc_count      in   NUM_ENC*CNT_W  channel i count at [i*CNT_W +: CNT_W]
//  zero_req       in   NUM_ENC        1-cycle pulse: zero channel i's position at next snapshot
//  out_valid      out  1              record available
//  out_ready      in   1              downstream accepts record when out_valid&&out_ready
//  out_channel    out  clog2(NUM_ENC) channel index of record (min width 1)
//  out_position   out  CNT_W          snapshot minus offset (modular)
//  out_velocity   out  VEL_W          saturated signed delta since previous frame
//  out_last       out  1              record is channel NUM_ENC-1
//  busy           out  1              FSM not IDLE
//  overrun_cnt    out  16             ticks dropped because FSM busy (saturates at 16'hFFFF)
// BEHAVIOUR
//  Reset: every output/register 0 (out_valid=0, busy=0, overrun_cnt=0, offsets/prev=0, first_frame=1).
//  Prescaler: tick_cnt 0..sample_period; tick asserted 1 cycle when tick_cnt==sample_period && enable.
//    enable=0: tick_cnt held at 0. sample_period=0: tick every cycle.
//  FSM: IDLE -> (tick) SNAP -> CALC -> EMIT -> (accepted && ch<NUM_ENC-1) CALC with ch+1 | (accepted, last) IDLE.
//  SNAP (1 cycle):
//    - snap[i]<=enc_count[i] for all i.
//    - zpend_frame <= zpend|zero_req; zpend cleared.
//    - ch<=0.
//  CALC (1 cycle), for ch:
//    - delta = snap-prev (CNT_W modular, two's complement).
//    - vel = 0 if first_frame, else delta saturated to [-2^(VEL_W-1), 2^(VEL_W-1)-1].
//    - If zpend_frame[ch]: offset[ch]<=snap, position=0; else position=snap-offset[ch].
//    - prev[ch]<=snap. Output regs loaded.
//  EMIT: out_valid=1; all out_* held stable until out_ready. Clears first_frame after last record accepted.
//  Latency: tick in cycle N (IDLE) -> SNAP N+1 -> CALC N+2 -> out_valid N+3.
//    Ready held high: one record per 2 cycles.
//  zero_req:
//    - Sticky in zpend until consumed by a SNAP; a pulse in the SNAP cycle itself applies to that frame.
//    - Zeroing does not affect velocity.
//  Tick while busy: dropped, overrun_cnt++ (saturating); the frame in progress is never aborted.
//  enable falling mid-frame: frame completes normally.
//  Counter wrap (e.g. 0xFFFFFFFE -> 0x00000003): vel=+5 via modular subtract.
//  reset_n asserted mid-frame: out_valid drops asynchronously; next frame after release reports vel=0.
// STRUCTURE
//  Package quad_sched_pkg:
//    - state enum {IDLE,SNAP,CALC,EMIT}
//    - function sat_vel(delta) -> VEL_W
//    - localparam CH_W = (NUM_ENC>1)?$clog2(NUM_ENC):1
//  Sub-module quad_sample_prescaler (tick generator: clk, reset_n, enable, sample_period -> tick).
//  Per-channel snap/prev/offset held as register arrays; single shared subtractor/saturator muxed by ch.
// TESTING
//  1. NUM_ENC=4, period=9, all counts 100 -> frame every 10 clk; 4 records ch0..3, pos=100, vel=0, last on ch3.
//  2. ch1 +5 between frames -> vel=5; ch1 -300 -> vel=-300 (0xFED4); other channels vel=0.
//  3. Delta +40000 -> vel=32767; -40000 -> -32768; count 0xFFFFFFFE -> 0x00000003 -> vel=5.
//  4. zero_req[2] with count 1000, next frame 1010 -> pos 0 then 10; vel 10 in second frame.
//  5. period=3, out_ready low 40 cycles mid-frame -> out_* stable, overrun_cnt=10; resumes without loss.
//  6. reset_n low in EMIT -> out_valid=0 at once, overrun_cnt=0; first frame after release vel=0 all ch.

Source files
------------

// File: rtl/quad_sample_scheduler_pkg.sv
// Shared types and helpers for the quadrature sample scheduler.
package quad_sched_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StSnap,
        StCalc,
        StEmit
    } state_e;

    localparam int unsigned DefNumEnc = 4;
    localparam int unsigned DefCntW   = 32;
    localparam int unsigned DefVelW   = 16;
    localparam int unsigned DefPerW   = 24;

    // Channel index width, never narrower than one bit
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CH_W = ch_width(DefNumEnc);

    // Clamp a sign-extended delta into the signed range of a vel_w-bit field.
    // Callers keep the low vel_w bits of the result.
    function automatic logic signed [63:0] sat_vel(input logic signed [63:0] delta,
                                                   input int unsigned      vel_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        hi  = (64'sd1 <<< (vel_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (vel_w - 1));
        res = delta;
        if (delta > hi) begin
            res = hi;
        end else if (delta < lo) begin
            res = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/quad_sample_scheduler_if.sv
// Position/velocity record stream from the scheduler to the host.
interface quad_sample_scheduler_if #(
    parameter int unsigned CH_W  = 2,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned VEL_W = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_channel;
    logic [CNT_W-1:0] out_position;
    logic [VEL_W-1:0] out_velocity;
    logic             out_last;

    modport master (
        output out_valid, out_channel, out_position, out_velocity, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_channel, out_position, out_velocity, out_last,
        output out_ready
    );
endinterface

// File: rtl/quad_sample_prescaler.sv
// Sample tick generator: one-cycle tick every sample_period+1 cycles while enabled.
module quad_sample_prescaler #(
    parameter int unsigned PER_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [PER_W-1:0] sample_period,
    output logic             tick
);
    logic [PER_W-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == sample_period);

    // Next count: held at 0 when disabled; >= recovers if the period shrinks mid-count
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q >= sample_period) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/quad_sample_scheduler.sv
// Periodic snapshot of all encoder counts, then one position/velocity record
// per channel on the output stream, using one shared subtract/saturate path.
module quad_sample_scheduler
    import quad_sched_pkg::*;
#(
    parameter int unsigned NUM_ENC = DefNumEnc,
    parameter int unsigned CNT_W   = DefCntW,   // must not exceed 64
    parameter int unsigned VEL_W   = DefVelW,
    parameter int unsigned PER_W   = DefPerW
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [PER_W-1:0]         sample_period,
    input  logic [NUM_ENC*CNT_W-1:0] enc_count,
    input  logic [NUM_ENC-1:0]       zero_req,
    output logic                     busy,
    output logic [15:0]              overrun_cnt,
    quad_sample_scheduler_if.master  out_if
);
    localparam int unsigned    ChW    = ch_width(NUM_ENC);
    localparam logic [ChW-1:0] LastCh = ChW'(NUM_ENC - 1);

    state_e state_q, state_d;
    logic   tick;
    logic   accept;
    logic   is_last;

    logic [CNT_W-1:0]   snap_q   [NUM_ENC];
    logic [CNT_W-1:0]   prev_q   [NUM_ENC];
    logic [CNT_W-1:0]   offset_q [NUM_ENC];
    logic [NUM_ENC-1:0] zpend_q, zpend_frame_q;
    logic [ChW-1:0]     ch_q;
    logic               first_frame_q;
    logic [15:0]        ovr_q;

    logic [ChW-1:0]     out_ch_q;
    logic [CNT_W-1:0]   pos_q;
    logic [VEL_W-1:0]   vel_q;
    logic               last_q;

    logic [CNT_W-1:0]   cur_snap;
    logic [CNT_W-1:0]   delta;
    logic signed [63:0] delta_ext;
    logic [CNT_W-1:0]   pos_calc;
    logic [VEL_W-1:0]   vel_calc;

    quad_sample_prescaler #(
        .PER_W(PER_W)
    ) u_prescaler (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .sample_period(sample_period),
        .tick         (tick)
    );

    assign accept  = (state_q == StEmit) && out_if.out_ready;
    assign is_last = (ch_q == LastCh);

    // Shared datapath for the channel currently selected by ch_q
    assign cur_snap  = snap_q[ch_q];
    assign delta     = cur_snap - prev_q[ch_q];
    assign delta_ext = 64'(signed'(delta));
    assign vel_calc  = first_frame_q ? '0 : VEL_W'(sat_vel(delta_ext, VEL_W));
    assign pos_calc  = zpend_frame_q[ch_q] ? '0 : (cur_snap - offset_q[ch_q]);

    // Next-state logic of the frame sequencer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (tick) state_d = StSnap;
            StSnap:  state_d = StCalc;
            StCalc:  state_d = StEmit;
            StEmit:  if (out_if.out_ready) state_d = is_last ? StIdle : StCalc;
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Snapshot capture and sticky zero requests; a pulse in the SNAP cycle joins that frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENC; i++) snap_q[i] <= '0;
            zpend_q       <= '0;
            zpend_frame_q <= '0;
        end else if (state_q == StSnap) begin
            for (int i = 0; i < NUM_ENC; i++) snap_q[i] <= enc_count[i*CNT_W +: CNT_W];
            zpend_frame_q <= zpend_q | zero_req;
            zpend_q       <= '0;
        end else begin
            zpend_q <= zpend_q | zero_req;
        end
    end

    // Per-channel history and the output record, loaded in CALC
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENC; i++) begin
                prev_q[i]   <= '0;
                offset_q[i] <= '0;
            end
            out_ch_q <= '0;
            pos_q    <= '0;
            vel_q    <= '0;
            last_q   <= 1'b0;
        end else if (state_q == StCalc) begin
            prev_q[ch_q] <= cur_snap;
            if (zpend_frame_q[ch_q]) offset_q[ch_q] <= cur_snap;
            out_ch_q <= ch_q;
            pos_q    <= pos_calc;
            vel_q    <= vel_calc;
            last_q   <= is_last;
        end
    end

    // Channel sequencing; velocity reporting starts once a full frame has gone out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_q          <= '0;
            first_frame_q <= 1'b1;
        end else if (state_q == StSnap) begin
            ch_q <= '0;
        end else if (accept) begin
            if (is_last) begin
                first_frame_q <= 1'b0;
            end else begin
                ch_q <= ch_q + 1'b1;
            end
        end
    end

    // Saturating count of ticks that arrive while a frame is in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr_q <= '0;
        end else if (tick && (state_q != StIdle) && (ovr_q != 16'hFFFF)) begin
            ovr_q <= ovr_q + 16'd1;
        end
    end

    assign out_if.out_valid    = (state_q == StEmit);
    assign out_if.out_channel  = out_ch_q;
    assign out_if.out_position = pos_q;
    assign out_if.out_velocity = vel_q;
    assign out_if.out_last     = last_q;
    assign busy                = (state_q != StIdle);
    assign overrun_cnt         = ovr_q;
endmodule

// File: tb/tb_quad_sample_scheduler.sv
// Bench for quad_sample_scheduler: frame-level reference model checked every
// cycle, directed literal scenarios, then randomized traffic.
module tb_quad_sample_scheduler;
    localparam int NE = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [23:0]   sample_period = 24'd9;
    logic [127:0]  enc_count;
    logic [3:0]    zero_req = 4'b0;
    logic          busy;
    logic [15:0]   overrun_cnt;
    logic [31:0]   cnt_v [NE];

    int total = 0;
    int bad   = 0;

    quad_sample_scheduler_if #(.CH_W(2), .CNT_W(32), .VEL_W(16)) bus ();

    quad_sample_scheduler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .sample_period(sample_period),
        .enc_count    (enc_count),
        .zero_req     (zero_req),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt),
        .out_if       (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        enc_count = '0;
        for (int i = 0; i < NE; i++) enc_count[i*32 +: 32] = cnt_v[i];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    typedef struct {
        int          ch;
        logic [31:0] pos;
        logic [15:0] vel;
        bit          last;
    } rec_t;

    rec_t        m_q[$];
    bit          m_busy  = 0;
    bit          m_snap  = 0;
    bit          m_valid = 0;
    bit          m_first = 1;
    int          m_gap   = 0;
    int          m_ovr   = 0;
    int unsigned m_cnt   = 0;
    logic [31:0] m_prev [NE];
    logic [31:0] m_off  [NE];
    logic [3:0]  m_zpend = 4'b0;
    bit          m_tick, m_start, m_acc;

    task automatic build_frame();
        logic [3:0] zm;
        zm = m_zpend | zero_req;
        m_zpend = 4'b0;
        for (int i = 0; i < NE; i++) begin
            rec_t        r;
            logic [31:0] s;
            logic [31:0] d;
            longint      dl;
            longint      v;
            s  = enc_count[i*32 +: 32];
            d  = s - m_prev[i];
            dl = longint'($signed(d));
            if (m_first) v = 0;
            else if (dl > 32767) v = 32767;
            else if (dl < -32768) v = -32768;
            else v = dl;
            if (zm[i]) begin
                m_off[i] = s;
                r.pos = 32'd0;
            end else begin
                r.pos = s - m_off[i];
            end
            m_prev[i] = s;
            r.ch   = i;
            r.vel  = 16'(v);
            r.last = (i == NE - 1);
            m_q.push_back(r);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_busy = 0; m_snap = 0; m_valid = 0; m_first = 1;
            m_gap = 0; m_ovr = 0; m_cnt = 0; m_zpend = 4'b0;
            for (int i = 0; i < NE; i++) begin
                m_prev[i] = 32'd0;
                m_off[i]  = 32'd0;
            end
        end else begin
            m_tick  = enable && (m_cnt == sample_period);
            m_cnt   = !enable ? 0 : ((m_cnt >= sample_period) ? 0 : m_cnt + 1);
            m_acc   = m_valid && bus.out_ready;
            m_start = 0;
            if (m_tick) begin
                if (m_busy) begin
                    if (m_ovr < 65535) m_ovr++;
                end else begin
                    m_start = 1;
                end
            end
            if (m_snap) begin
                build_frame();
                m_snap = 0;
                m_gap  = 1;
            end else begin
                m_zpend = m_zpend | zero_req;
                if (m_gap > 0) begin
                    m_gap--;
                    if (m_gap == 0) m_valid = 1;
                end else if (m_acc) begin
                    void'(m_q.pop_front());
                    m_valid = 0;
                    if (m_q.size() == 0) begin
                        m_busy  = 0;
                        m_first = 0;
                    end else begin
                        m_gap = 1;
                    end
                end
            end
            if (m_start) begin
                m_busy = 1;
                m_snap = 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (reset_n) begin
            chk("valid", bus.out_valid, 64'(m_valid));
            chk("busy", busy, 64'(m_busy));
            chk("overrun", overrun_cnt, 64'(m_ovr));
            if (m_valid && m_q.size() > 0) begin
                chk("channel", bus.out_channel, 64'(m_q[0].ch));
                chk("position", bus.out_position, m_q[0].pos);
                chk("velocity", bus.out_velocity, m_q[0].vel);
                chk("last", bus.out_last, 64'(m_q[0].last));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_valid: got no record expected one within 200 cycles");
        end
    endtask

    task automatic expect_rec(input int ch, input logic [31:0] pos, input logic [15:0] vel);
        bit ok;
        wait_valid(ok);
        if (ok) begin
            chk("lit_channel", bus.out_channel, 64'(ch));
            chk("lit_position", bus.out_position, pos);
            chk("lit_velocity", bus.out_velocity, vel);
            chk("lit_last", bus.out_last, 64'(ch == NE - 1));
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got busy expected idle within 300 cycles");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ov0;
        logic [31:0] p0;
        logic [15:0] v0;
        logic [1:0]  c0;
        bit          ok;

        for (int i = 0; i < NE; i++) cnt_v[i] = 32'd100;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overrun", overrun_cnt, 0);
        #10 reset_n = 1'b1;
        @(posedge clk); #2;
        enable = 1'b1;

        // 1: first frame, velocity suppressed
        for (int i = 0; i < NE; i++) expect_rec(i, 32'd100, 16'd0);

        // 2: small positive and negative deltas on ch1
        cnt_v[1] = 32'd105;
        expect_rec(0, 32'd100, 16'd0);
        expect_rec(1, 32'd105, 16'd5);
        expect_rec(2, 32'd100, 16'd0);
        expect_rec(3, 32'd100, 16'd0);
        cnt_v[1] = 32'hFFFF_FF3D;
        expect_rec(0, 32'd100, 16'd0);
        expect_rec(1, 32'hFFFF_FF3D, 16'hFED4);
        expect_rec(2, 32'd100, 16'd0);
        expect_rec(3, 32'd100, 16'd0);

        // 3: saturation both ways and counter wrap
        cnt_v[0] = 32'd40100;
        cnt_v[3] = 32'hFFFF_FFFE;
        expect_rec(0, 32'd40100, 16'h7FFF);
        expect_rec(1, 32'hFFFF_FF3D, 16'd0);
        expect_rec(2, 32'd100, 16'd0);
        expect_rec(3, 32'hFFFF_FFFE, 16'hFF9A);
        cnt_v[0] = 32'd100;
        cnt_v[3] = 32'd3;
        expect_rec(0, 32'd100, 16'h8000);
        expect_rec(1, 32'hFFFF_FF3D, 16'd0);
        expect_rec(2, 32'd100, 16'd0);
        expect_rec(3, 32'd3, 16'd5);

        // 4: zero request on ch2
        cnt_v[2] = 32'd1000;
        zero_req = 4'b0100;
        @(negedge clk);
        zero_req = 4'b0000;
        expect_rec(0, 32'd100, 16'd0);
        expect_rec(1, 32'hFFFF_FF3D, 16'd0);
        expect_rec(2, 32'd0, 16'd900);
        expect_rec(3, 32'd3, 16'd0);
        cnt_v[2] = 32'd1010;
        expect_rec(0, 32'd100, 16'd0);
        expect_rec(1, 32'hFFFF_FF3D, 16'd0);
        expect_rec(2, 32'd10, 16'd10);
        expect_rec(3, 32'd3, 16'd0);

        // 5: backpressure with a short period
        enable = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        sample_period = 24'd3;
        enable = 1'b1;
        wait_valid(ok);
        ov0 = overrun_cnt;
        p0  = bus.out_position;
        v0  = bus.out_velocity;
        c0  = bus.out_channel;
        bus.out_ready = 1'b0;
        repeat (40) @(negedge clk);
        chk("stall_overrun_delta", 64'(overrun_cnt - ov0), 10);
        chk("stall_position", bus.out_position, p0);
        chk("stall_velocity", bus.out_velocity, v0);
        chk("stall_channel", bus.out_channel, c0);
        chk("stall_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        repeat (30) @(negedge clk);
        enable = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        sample_period = 24'd9;
        enable = 1'b1;

        // 6: reset during EMIT
        wait_valid(ok);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun_cnt, 0);
        for (int i = 0; i < NE; i++) cnt_v[i] = 32'h1000 * (i + 1) + 32'd7;
        #20 reset_n = 1'b1;
        for (int i = 0; i < NE; i++) expect_rec(i, 32'h1000 * (i + 1) + 32'd7, 16'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #2;
            bus.out_ready = ($urandom % 4) != 0;
            if (($urandom % 8) == 0) begin
                int k;
                k = $urandom_range(0, NE - 1);
                if (($urandom % 4) == 0) cnt_v[k] = $urandom;
                else cnt_v[k] = cnt_v[k] + 32'($urandom_range(0, 200)) - 32'd100;
            end
            zero_req = (($urandom % 32) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
            if (!enable && (($urandom % 4) == 0)) sample_period = 24'($urandom_range(0, 12));
            if (($urandom % 200) == 0) enable = ~enable;
        end
        bus.out_ready = 1'b1;
        zero_req = 4'b0;
        repeat (40) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
